// File: rtl/x_sram_arb.sv
// x_sram_arb: round-robin arbiter with burst lock in front of a single-port SRAM.
// Requester 0 = loader, 1 = compute read, 2 = write-back. Reads answer one cycle
// after their handshake on a shared rdata_o with a per-requester rvalid_o strobe.
module x_sram_arb #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = 9,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [NREQ-1:0]      req_lock_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      rvalid_o,
  output logic [DW-1:0]        rdata_o,
  output logic [AW-1:0]        sram_adr_o,
  output logic [DW-1:0]        sram_d_o,
  output logic                 sram_we_o,
  output logic                 sram_me_o,
  input  logic [DW-1:0]        sram_q_i
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Count value at which the next locked handshake forces a release.
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  logic [0:0]      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic [NREQ-1:0] gnt;
  logic            hs;
  logic [IW-1:0]   win;
  int unsigned     idx;

  // Grant selection: locked owner only, otherwise round-robin after last_grant.
  always_comb begin
    gnt = '0;
    hs  = 1'b0;
    win = '0;
    idx = 0;
    if (!rst_ni) begin
      if (state_q == ST_LOCKED) begin
        if (req_valid_i[owner_q]) begin
          gnt[owner_q] = 1'b1;
          hs           = 1'b1;
          win          = owner_q;
        end
      end else begin
        for (int unsigned k = 1; k <= NREQ; k++) begin
          idx = (32'(last_q) + k) % NREQ;
          if (!hs && req_valid_i[idx]) begin
            gnt[idx] = 1'b1;
            hs       = 1'b1;
            win      = IW'(idx);
          end
        end
      end
    end
  end

  // Next-state: last grant, lock engage/release and read-response strobe.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    if (hs) begin
      last_d = win;
      if (!req_we_i[win]) begin
        rvalid_d[win] = 1'b1;
      end
    end
    if (state_q == ST_LOCKED) begin
      // Owner idle, owner drops lock, or burst limit all end the lock; the
      // owner is already last_grant, so round-robin skips it next.
      if (!req_valid_i[owner_q] || !req_lock_i[owner_q] || (cnt_q == CNT_LAST)) begin
        state_d = ST_FREE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (hs && req_lock_i[win] && (LOCK_MAX > 1)) begin
      state_d = ST_LOCKED;
      owner_d = win;
      cnt_d   = CW'(1);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q  <= ST_FREE;
      last_q   <= IW'(NREQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  // SRAM drive from the winner; everything is zero without a handshake.
  always_comb begin
    sram_me_o  = hs;
    sram_we_o  = 1'b0;
    sram_adr_o = '0;
    sram_d_o   = '0;
    if (hs) begin
      sram_we_o  = req_we_i[win];
      sram_adr_o = req_addr_i[32'(win)*AW +: AW];
      sram_d_o   = req_wdata_i[32'(win)*DW +: DW];
    end
  end

  assign req_ready_o = gnt;
  // Suppress a strobe from a read issued just before reset asserted.
  assign rvalid_o    = rst_ni ? '0 : rvalid_q;
  assign rdata_o     = sram_q_i;

endmodule
